// File: rtl/boot_pkg.sv
// Shared definitions for the boot copy engine: FSM state encoding and the
// checksum accumulation rule, also used by the ROM image generator's checker.
package boot_pkg;

    localparam int BOOT_STATE_W = 3;

    // Widest word the checksum helper handles; callers truncate to their width.
    localparam int BOOT_SUM_W = 64;

    typedef enum logic [BOOT_STATE_W-1:0] {
        BOOT_IDLE  = 3'd0,
        BOOT_COPY  = 3'd1,
        BOOT_CHECK = 3'd2,
        BOOT_DONE  = 3'd3,
        BOOT_FAIL  = 3'd4
    } boot_state_t;

    // Checksum is a plain wrapping sum; truncating the result to the word
    // width gives the sum modulo 2^DATA_WIDTH.
    function automatic logic [BOOT_SUM_W-1:0] boot_sum(
        input logic [BOOT_SUM_W-1:0] acc,
        input logic [BOOT_SUM_W-1:0] word
    );
        return acc + word;
    endfunction

endpackage

// File: rtl/boot_rd_pipe.sv
// Valid/tag delay line matching the boot ROM read latency. The tail stage is
// high in the cycle the ROM presents data for the tagged read, so the caller
// samples boot_mem_rd_data directly alongside o_valid/o_tag.
module boot_rd_pipe #(
    parameter int LATENCY = 1,
    parameter int TAG_W   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    output logic [TAG_W-1:0] o_tag
);

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            logic             r_vld;
            logic [TAG_W-1:0] r_tag;
            logic             w_vld_in;
            logic [TAG_W-1:0] w_tag_in;

            if (gi == 0) begin : g_head
                assign w_vld_in = i_valid;
                assign w_tag_in = i_tag;
            end else begin : g_body
                assign w_vld_in = g_stage[gi-1].r_vld;
                assign w_tag_in = g_stage[gi-1].r_tag;
            end

            // Advance the outstanding-read marker by one stage per clock.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= 1'b0;
                    r_tag <= '0;
                end else begin
                    r_vld <= w_vld_in;
                    r_tag <= w_tag_in;
                end
            end
        end
    endgenerate

    assign o_valid = g_stage[LATENCY-1].r_vld;
    assign o_tag   = g_stage[LATENCY-1].r_tag;

endmodule

// File: rtl/boot_copy_engine.sv
// Copies a boot image from ROM into instruction SRAM, one read per cycle,
// optionally verifying a trailing checksum word before releasing the core.
module boot_copy_engine
    import boot_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 20,
    parameter int IMAGE_WORDS  = 'h120,
    parameter int READ_LATENCY = 1,
    parameter int SRC_BASE     = 0,
    parameter int DST_BASE     = 0,
    parameter int ADDR_SHIFT   = 2,
    parameter int CHECK_EN     = 1,
    parameter int AUTO_START   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  boot_mem_rd_en,
    output logic [ADDR_WIDTH-1:0] boot_mem_addr,
    input  logic [DATA_WIDTH-1:0] boot_mem_rd_data,
    output logic                  inst_mem_wr_en,
    output logic [DATA_WIDTH-1:0] inst_mem_wr_data,
    output logic [ADDR_WIDTH-1:0] inst_mem_addr,
    output logic                  boot_mode,
    output logic                  boot_done,
    output logic                  boot_error,
    output logic [ADDR_WIDTH-1:0] words_copied
);

    // Reads include the trailer word when checking is enabled.
    localparam int N_RD  = IMAGE_WORDS + ((CHECK_EN != 0) ? 1 : 0);
    localparam int CNT_W = $clog2(N_RD + 1);

    boot_state_t           r_state;
    boot_state_t           w_state_next;
    logic                  r_first;
    logic                  w_enter_copy;
    logic [CNT_W-1:0]      r_rd_idx;
    logic [CNT_W-1:0]      r_rd_tag;
    logic [CNT_W-1:0]      r_ret_cnt;
    logic [CNT_W-1:0]      r_wr_idx;
    logic                  w_ret_valid;
    logic [CNT_W-1:0]      w_ret_tag;
    logic [DATA_WIDTH-1:0] r_sum;
    logic [DATA_WIDTH-1:0] r_trailer;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_wr_en;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH-1:0] r_words;
    logic                  r_boot_mode;
    logic                  r_boot_done;
    logic                  r_boot_error;

    // State register; r_first marks the first clock after reset for auto-start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT_IDLE;
            r_first <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_first <= 1'b0;
        end
    end

    // Next-state logic; start only matters in IDLE, DONE and FAIL.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BOOT_IDLE: begin
                if (((AUTO_START != 0) && r_first) || start)
                    w_state_next = BOOT_COPY;
            end
            BOOT_COPY: begin
                if (r_ret_cnt == CNT_W'(N_RD))
                    w_state_next = BOOT_CHECK;
            end
            BOOT_CHECK: begin
                if ((CHECK_EN == 0) || (r_sum == r_trailer))
                    w_state_next = BOOT_DONE;
                else
                    w_state_next = BOOT_FAIL;
            end
            BOOT_DONE, BOOT_FAIL: begin
                if (start)
                    w_state_next = BOOT_COPY;
            end
            default: w_state_next = BOOT_IDLE;
        endcase
    end

    assign w_enter_copy = (w_state_next == BOOT_COPY) && (r_state != BOOT_COPY);

    // Read issue: one strobe per cycle for N_RD cycles after entering COPY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_idx  <= '0;
            r_rd_tag  <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
        end else if (w_enter_copy) begin
            r_rd_idx  <= '0;
            r_rd_tag  <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
        end else if ((r_state == BOOT_COPY) && (r_rd_idx < CNT_W'(N_RD))) begin
            r_rd_idx  <= r_rd_idx + CNT_W'(1);
            r_rd_tag  <= r_rd_idx;
            r_rd_en   <= 1'b1;
            r_rd_addr <= ADDR_WIDTH'(SRC_BASE) + ADDR_WIDTH'(r_rd_idx);
        end else begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
        end
    end

    boot_rd_pipe #(
        .LATENCY (READ_LATENCY),
        .TAG_W   (CNT_W)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (r_rd_en),
        .i_tag   (r_rd_tag),
        .o_valid (w_ret_valid),
        .o_tag   (w_ret_tag)
    );

    // Return side: image words become SRAM writes, the trailer is kept aside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_wr_addr <= '0;
            r_wr_idx  <= '0;
            r_words   <= '0;
            r_sum     <= '0;
            r_trailer <= '0;
            r_ret_cnt <= '0;
        end else begin
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_wr_addr <= '0;
            if (w_enter_copy) begin
                r_wr_idx  <= '0;
                r_words   <= '0;
                r_sum     <= '0;
                r_trailer <= '0;
                r_ret_cnt <= '0;
            end else if (w_ret_valid) begin
                r_ret_cnt <= r_ret_cnt + CNT_W'(1);
                if (w_ret_tag < CNT_W'(IMAGE_WORDS)) begin
                    r_wr_en   <= 1'b1;
                    r_wr_data <= boot_mem_rd_data;
                    r_wr_addr <= ADDR_WIDTH'(DST_BASE) + (ADDR_WIDTH'(r_wr_idx) << ADDR_SHIFT);
                    r_wr_idx  <= r_wr_idx + CNT_W'(1);
                    r_words   <= r_words + ADDR_WIDTH'(1);
                    r_sum     <= DATA_WIDTH'(boot_sum(BOOT_SUM_W'(r_sum), BOOT_SUM_W'(boot_mem_rd_data)));
                end else begin
                    r_trailer <= boot_mem_rd_data;
                end
            end
        end
    end

    // Core hold / status flags, updated on copy entry and when CHECK resolves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_boot_mode  <= 1'b1;
            r_boot_done  <= 1'b0;
            r_boot_error <= 1'b0;
        end else if (w_enter_copy) begin
            r_boot_mode  <= 1'b1;
            r_boot_done  <= 1'b0;
            r_boot_error <= 1'b0;
        end else if (r_state == BOOT_CHECK) begin
            if (w_state_next == BOOT_DONE) begin
                r_boot_mode <= 1'b0;
                r_boot_done <= 1'b1;
            end else begin
                r_boot_error <= 1'b1;
            end
        end
    end

    assign boot_mem_rd_en   = r_rd_en;
    assign boot_mem_addr    = r_rd_addr;
    assign inst_mem_wr_en   = r_wr_en;
    assign inst_mem_wr_data = r_wr_data;
    assign inst_mem_addr    = r_wr_addr;
    assign boot_mode        = r_boot_mode;
    assign boot_done        = r_boot_done;
    assign boot_error       = r_boot_error;
    assign words_copied     = r_words;

endmodule

// File: doc/boot_copy_engine.md
Name: boot_copy_engine

Overview:
- Parametrised successor to the current boot copier: copies an image of IMAGE_WORDS words from boot ROM into instruction memory at power-up, or again on a start request.
- Pipelined: issues one read per cycle and tolerates READ_LATENCY cycles of memory latency.
- Optionally verifies a trailing checksum word before releasing the core from boot_mode.
- Sits between the boot ROM, the instruction SRAM write port and the core's boot_mode stall input.

Parameters:
- DATA_WIDTH, 32: memory word width.
- ADDR_WIDTH, 20: width of both address buses.
- IMAGE_WORDS, 'h120: words copied; must be ≥1.
- READ_LATENCY, 1: cycles from boot_mem_rd_en to valid boot_mem_rd_data; range 1..4.
- SRC_BASE, 0: boot ROM word address of image word 0.
- DST_BASE, 0: instruction memory byte address of image word 0.
- ADDR_SHIFT, 2: log2 of bytes per word on the instruction memory address.
- CHECK_EN, 1: when 1, ROM word SRC_BASE+IMAGE_WORDS holds the expected checksum.
- AUTO_START, 1: when 1, the copy starts automatically after reset.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: single-cycle copy request.
- boot_mem_rd_en, out, 1: ROM read strobe.
- boot_mem_addr, out, ADDR_WIDTH: ROM word address.
- boot_mem_rd_data, in, DATA_WIDTH: ROM read data.
- inst_mem_wr_en, out, 1: SRAM write strobe.
- inst_mem_wr_data, out, DATA_WIDTH: SRAM write data.
- inst_mem_addr, out, ADDR_WIDTH: SRAM byte address.
- boot_mode, out, 1: high while the core must be held.
- boot_done, out, 1: copy finished and checksum passed (or CHECK_EN=0).
- boot_error, out, 1: checksum mismatch.
- words_copied, out, ADDR_WIDTH: count of write strobes issued since the last start.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0 except boot_mode=1; state IDLE; counters and checksum 0.
- States:
  - IDLE: go to COPY when (AUTO_START and first cycle after reset) or start=1.
  - COPY: issue reads; go to CHECK when all returns have been consumed.
  - CHECK: one cycle; go to DONE if CHECK_EN=0 or sum==trailer, else FAIL.
  - DONE and FAIL: start=1 re-enters COPY.
  - start is ignored in COPY and CHECK.
- Read side:
  - N_RD = IMAGE_WORDS + CHECK_EN.
  - On entering COPY, clear rd_idx, wr_idx, sum and words_copied; clear boot_done and boot_error; set boot_mode=1.
  - boot_mem_rd_en is registered and high for exactly N_RD consecutive cycles, starting the cycle after the state enters COPY.
  - boot_mem_addr = SRC_BASE + rd_idx, truncated to ADDR_WIDTH; rd_idx increments per read.
- Return side:
  - A READ_LATENCY-deep valid shift register tracks outstanding reads.
  - Data for a read issued in cycle c is sampled at cycle c+READ_LATENCY.
- Write side:
  - For returns 0..IMAGE_WORDS-1: in the next cycle, drive registered inst_mem_wr_en=1, inst_mem_wr_data=sampled word, and inst_mem_addr=DST_BASE+(wr_idx<<ADDR_SHIFT), truncated to ADDR_WIDTH.
  - Then increment wr_idx and words_copied; sum += word, modulo 2^DATA_WIDTH.
  - Return IMAGE_WORDS (CHECK_EN=1) is captured as the trailer and not written.
  - inst_mem_addr = 0 whenever wr_en = 0.
- Latency (CHECK_EN=0): first write strobe occurs READ_LATENCY+1 cycles after the first rd_en; the last write is followed by CHECK on the next cycle.
- DONE: boot_mode=0 and boot_done=1 from the cycle after CHECK.
- FAIL: boot_error=1; boot_mode stays 1.
- Address wrap: overflow of SRC/DST addresses silently wraps; no error is flagged.
- Reset mid-COPY: aborts immediately, no further strobes. With AUTO_START=1 the copy restarts from word 0 after reset release.
- start arriving in the same cycle the state enters DONE or FAIL: ignored. It is accepted only when sampled while the state is DONE, FAIL or IDLE.

Decomposition:
- Shared package boot_pkg holds:
  - state enum BOOT_IDLE/COPY/CHECK/DONE/FAIL, 3-bit;
  - localparam BOOT_STATE_W;
  - checksum function boot_sum(acc, word), reused by the ROM image generator's checker.
- One sub-module, boot_rd_pipe: parametrised READ_LATENCY valid/data delay line with a return-index tag. The FSM, counters and checksum stay in the top module.

Test Plan:
- Defaults, CHECK_EN=0, ROM[i]=i*4+1:
  - exactly 288 writes; addr 0x000..0x47C step 4; data match;
  - boot_mode falls 1 cycle after CHECK; words_copied=0x120.
- READ_LATENCY=3, IMAGE_WORDS=8, DST_BASE=0x1000:
  - first wr_en 4 cycles after first rd_en;
  - 8 back-to-back strobes at 0x1000..0x101C.
- CHECK_EN=1, ROM[0..3]=1,2,3,4, ROM[4]=10 → boot_done=1, boot_error=0, no write to 0x10.
- Same image with ROM[4]=11 → boot_error=1, boot_mode stays 1. Then start pulse with ROM[4]=10 → recopy 4 words, boot_done=1.
- rst_n low after the 5th write:
  - all outputs return to reset values asynchronously;
  - after release the copy restarts with addr 0 and words_copied counts from 0.
- start held high during COPY → no restart, identical write sequence. AUTO_START=0 → no reads until the first start.
